// File: rtl/multicycle_control.sv
// multicycle_control
//
// Main control unit for a multi-cycle MIPS core. A Moore state machine steps
// every instruction through fetch, decode, execute, memory and write-back, and
// drives the datapath muxes, the register-file and memory enables and the
// 3-bit ALU-op code. It waits on a memory-ready handshake in FETCH,
// MEM_READ and MEM_WRITE, and it counts retired instructions.
//
// Optional feature macro: MULTICYCLE_MEM_OPS_EN
//   defined     : LW/SW are decoded and MEM_ADDR, MEM_READ, MEM_WRITE and
//                 WB_MEM are built.
//   not defined : those states do not exist, LW/SW decode to TRAP, and
//                 mem_write_o / mem_to_reg_o are constant 0.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   opcode_i       instruction bits [31:26] from the instruction register
//   mem_ready_i    memory finished the current read/write this cycle
//   pc_write_o     load PC
//   i_or_d_o       memory address select (0 = PC, 1 = ALU out)
//   mem_read_o     memory read request
//   mem_write_o    memory write request
//   ir_write_o     load instruction register
//   reg_dst_o      write-register select (0 = rt, 1 = rd)
//   mem_to_reg_o   write-data select (0 = ALU out, 1 = MDR)
//   reg_write_o    register-file write enable
//   alu_src_a_o    ALU A select (0 = PC, 1 = rs)
//   alu_src_b_o    ALU B select (00 rt, 01 const 4, 10 immediate)
//   alu_op_o       ALU op (000 idle, 100 add, 101 or, 110 lui, 111 R-type)
//   pc_src_o       PC source (00 ALU result, 01 jump target)
//   illegal_o      trap flag, held until reset
//   state_o        current state encoding
//   instr_count_o  retired-instruction count, wraps modulo 2^COUNT_W

module multicycle_control #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode_i,
   input  logic               mem_ready_i,
   output logic               pc_write_o,
   output logic               i_or_d_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic               ir_write_o,
   output logic               reg_dst_o,
   output logic               mem_to_reg_o,
   output logic               reg_write_o,
   output logic               alu_src_a_o,
   output logic [1:0]         alu_src_b_o,
   output logic [2:0]         alu_op_o,
   output logic [1:0]         pc_src_o,
   output logic               illegal_o,
   output logic [3:0]         state_o,
   output logic [COUNT_W-1:0] instr_count_o
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_MEM_OPS_EN
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
`endif

   // Encodings are fixed so state_o is identical with or without memory ops.
   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_EXEC_R    = 4'd2,
      ST_EXEC_I    = 4'd3,
`ifdef MULTICYCLE_MEM_OPS_EN
      ST_MEM_ADDR  = 4'd4,
      ST_MEM_READ  = 4'd5,
      ST_MEM_WRITE = 4'd6,
      ST_WB_MEM    = 4'd8,
`endif
      ST_WB_REG    = 4'd7,
      ST_JUMP      = 4'd9,
      ST_TRAP      = 4'd10
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_retire;
   logic [COUNT_W-1:0] r_count;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Retired-instruction counter; wraps naturally at 2^COUNT_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (w_retire) begin
         r_count <= r_count + COUNT_W'(1);
      end else begin
         r_count <= r_count;
      end
   end

   // Next-state decode and retirement strobe.
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (mem_ready_i) begin
               w_next = ST_DECODE;
            end else begin
               w_next = ST_FETCH;
            end
         end
         ST_DECODE: begin
            case (opcode_i)
               OP_R:                    w_next = ST_EXEC_R;
               OP_ADDI, OP_ORI, OP_LUI: w_next = ST_EXEC_I;
               OP_J:                    w_next = ST_JUMP;
`ifdef MULTICYCLE_MEM_OPS_EN
               OP_LW, OP_SW:            w_next = ST_MEM_ADDR;
`endif
               default:                 w_next = ST_TRAP;
            endcase
         end
         ST_EXEC_R: w_next = ST_WB_REG;
         ST_EXEC_I: w_next = ST_WB_REG;
         ST_WB_REG: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
`ifdef MULTICYCLE_MEM_OPS_EN
         // Only LW or SW can reach MEM_ADDR, so one compare picks the path.
         ST_MEM_ADDR: begin
            if (opcode_i == OP_SW) begin
               w_next = ST_MEM_WRITE;
            end else begin
               w_next = ST_MEM_READ;
            end
         end
         ST_MEM_READ: begin
            if (mem_ready_i) begin
               w_next = ST_WB_MEM;
            end else begin
               w_next = ST_MEM_READ;
            end
         end
         // A store retires on the edge its write is accepted.
         ST_MEM_WRITE: begin
            if (mem_ready_i) begin
               w_next   = ST_FETCH;
               w_retire = 1'b1;
            end else begin
               w_next   = ST_MEM_WRITE;
            end
         end
         ST_WB_MEM: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
`endif
         ST_JUMP: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
         ST_TRAP: w_next = ST_TRAP;
         // Unused encodings fall back to FETCH.
         default: w_next = ST_FETCH;
      endcase
   end

   // Moore output decode; only FETCH's write strobes look at mem_ready_i,
   // and they ignore it while reset is held.
   always_comb begin
      pc_write_o   = 1'b0;
      i_or_d_o     = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 3'b000;
      pc_src_o     = 2'b00;
      illegal_o    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            alu_op_o    = 3'b100;
            ir_write_o  = mem_ready_i & reset;
            pc_write_o  = mem_ready_i & reset;
         end
         ST_DECODE: begin
            alu_op_o = 3'b000;
         end
         ST_EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b00;
            alu_op_o    = 3'b111;
         end
         ST_EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            case (opcode_i)
               OP_ADDI: alu_op_o = 3'b100;
               OP_ORI:  alu_op_o = 3'b101;
               OP_LUI:  alu_op_o = 3'b110;
               default: alu_op_o = 3'b000;
            endcase
         end
         ST_WB_REG: begin
            reg_write_o = 1'b1;
            reg_dst_o   = (opcode_i == OP_R);
         end
`ifdef MULTICYCLE_MEM_OPS_EN
         ST_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o    = 3'b100;
         end
         ST_MEM_READ: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
         end
         ST_MEM_WRITE: begin
            mem_write_o = 1'b1;
            i_or_d_o    = 1'b1;
         end
         ST_WB_MEM: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
         end
`endif
         ST_JUMP: begin
            pc_write_o = 1'b1;
            pc_src_o   = 2'b01;
         end
         ST_TRAP: begin
            illegal_o = 1'b1;
         end
         default: begin
            illegal_o = 1'b0;
         end
      endcase
   end

   assign state_o       = r_state;
   assign instr_count_o = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. A program of instructions is
// expanded into per-cycle stimulus with the expected control word attached;
// the driver applies each cycle just after the rising edge and queues the
// expected word, and the monitor pops and compares on the falling edge.

module tb_multicycle_control;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode_i;
   logic        mem_ready_i;
   logic        pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
   logic        reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, illegal_o;
   logic [1:0]  alu_src_b_o, pc_src_o;
   logic [2:0]  alu_op_o;
   logic [3:0]  state_o;
   logic [31:0] instr_count_o;

   multicycle_control #(.COUNT_W(32)) dut (
      .clk(clk), .reset(reset), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(pc_write_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
      .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
      .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
      .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
      .pc_src_o(pc_src_o), .illegal_o(illegal_o), .state_o(state_o),
      .instr_count_o(instr_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, pcw, iord, mr, mw, irw, rd, m2r, rw, asa, ill, asb, aop, psrc, count}
   typedef logic [52:0] exp_t;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       rdy;
      exp_t       exp;
   } stim_t;

   stim_t       stim_q[$];
   exp_t        exp_q[$];
   logic [31:0] model_cnt;
   int          n_checks;
   int          n_fail;
   bit          driving_done;

   localparam logic [5:0] R = 6'h00, ADDI = 6'h08, ORI = 6'h0d, LUI = 6'h0f;
   localparam logic [5:0] J = 6'h02, LW = 6'h23, SW = 6'h2b, BAD = 6'h3f;

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic pcw, input logic iord,
                       input logic mr, input logic mw, input logic irw,
                       input logic rd, input logic m2r, input logic rw,
                       input logic asa, input logic [1:0] asb,
                       input logic [2:0] aop, input logic [1:0] psrc);
      stim_t s;
      s.rst = rst;
      s.op  = op;
      s.rdy = rdy;
      s.exp = {st, pcw, iord, mr, mw, irw, rd, m2r, rw, asa, (st == 4'd10),
               asb, aop, psrc, model_cnt};
      stim_q.push_back(s);
   endtask

   // Reset asserted for one cycle: FETCH outputs, strobes gated, count 0.
   task automatic do_reset();
      model_cnt = 32'd0;
      push(1'b0, 6'($urandom), 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b100, 2'b00);
   endtask

   task automatic fetch_decode(input logic [5:0] op, input int wf);
      for (int i = 0; i < wf; i++)
         push(1'b1, op, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b100, 2'b00);
      push(1'b1, op, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b100, 2'b00);
      push(1'b1, op, rbit(), 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00);
   endtask

   task automatic mem_addr(input logic [5:0] op);
      push(1'b1, op, rbit(), 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b100, 2'b00);
   endtask

   task automatic mem_read_wait(input logic [5:0] op, input int wm);
      for (int i = 0; i < wm; i++)
         push(1'b1, op, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00);
   endtask

   task automatic trap_cycles(input logic [5:0] op, input int n);
      for (int i = 0; i < n; i++)
         push(1'b1, op, rbit(), 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00);
      do_reset();
   endtask

   // One whole instruction: wf wait cycles in FETCH, wm in the memory state.
   task automatic instr(input logic [5:0] op, input int wf, input int wm);
      bit mem_en;
`ifdef MULTICYCLE_MEM_OPS_EN
      mem_en = 1'b1;
`else
      mem_en = 1'b0;
`endif
      fetch_decode(op, wf);
      if (op == R) begin
         push(1'b1, op, rbit(), 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111, 2'b00);
         push(1'b1, op, rbit(), 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00);
         model_cnt++;
      end else if (op == ADDI || op == ORI || op == LUI) begin
         push(1'b1, op, rbit(), 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
              (op == ADDI) ? 3'b100 : (op == ORI) ? 3'b101 : 3'b110, 2'b00);
         push(1'b1, op, rbit(), 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00);
         model_cnt++;
      end else if (op == J) begin
         push(1'b1, op, rbit(), 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b01);
         model_cnt++;
      end else if (mem_en && op == LW) begin
         mem_addr(op);
         mem_read_wait(op, wm);
         push(1'b1, op, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00);
         push(1'b1, op, rbit(), 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00);
         model_cnt++;
      end else if (mem_en && op == SW) begin
         mem_addr(op);
         for (int i = 0; i <= wm; i++)
            push(1'b1, op, (i == wm), 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00);
         model_cnt++;
      end else begin
         trap_cycles(op, 3);
      end
   endtask

   // Driver: one stimulus entry per cycle, applied just after the rising edge.
   initial begin
      stim_t s;
      logic [5:0] ops [8];
      ops = '{R, ADDI, ORI, LUI, J, LW, SW, BAD};
      reset = 1'b0;
      opcode_i = 6'h00;
      mem_ready_i = 1'b0;
      n_checks = 0;
      n_fail = 0;
      driving_done = 1'b0;
      model_cnt = 32'd0;

      do_reset();
      do_reset();
      instr(R, 0, 0);
      instr(ORI, 0, 0);
      instr(LUI, 0, 0);
      instr(J, 0, 0);
      instr(ADDI, 1, 0);
      instr(LW, 2, 3);
      instr(SW, 0, 0);
      instr(SW, 1, 2);
      for (int k = 0; k < 40; k++)
         instr(ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 2));
      instr(R, 0, 0);
      // Reset mid-instruction: abandoned, nothing retired, no write-back pulse.
      fetch_decode(LW, 1);
`ifdef MULTICYCLE_MEM_OPS_EN
      mem_addr(LW);
      mem_read_wait(LW, 2);
`else
      trap_cycles(LW, 2);
      instr(J, 0, 0);
      fetch_decode(R, 0);
      push(1'b1, R, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111, 2'b00);
`endif
      do_reset();
      instr(R, 0, 0);
      fetch_decode(BAD, 0);
      trap_cycles(BAD, 20);
      instr(ADDI, 0, 0);

      while (stim_q.size() > 0) begin
         @(posedge clk);
         #1;
         s = stim_q.pop_front();
         reset = s.rst;
         opcode_i = s.op;
         mem_ready_i = s.rdy;
         exp_q.push_back(s.exp);
      end
      @(posedge clk);
      @(posedge clk);
      driving_done = 1'b1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Monitor: compare the DUT's control word against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (!driving_done && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {state_o, pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
              reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, illegal_o,
              alu_src_b_o, alu_op_o, pc_src_o, instr_count_o};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL ctl_word t=%0t: got state=%0d word=%h cnt=%0d, required state=%0d word=%h cnt=%0d",
                     $time, a[52:49], a[52:32], a[31:0], e[52:49], e[52:32], e[31:0]);
         end
      end
   end

endmodule
